keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed seven-segment display driver.
- The display driver drives one-hot anode strobes outward. This block drives one-hot column strobes into a 4x4 key matrix and reads the four row lines back.
- It debounces the readback and delivers a single, stable 4-bit key code plus a one-cycle valid pulse, for the ALU/top-level datapath.

Parameters:
- SCAN_DIV, 16: clock cycles each column is driven (dwell); legal range >= 4.
- DEBOUNCE_FRAMES, 4: consecutive identical full-matrix frames needed to accept a press or a release; legal range >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- res  input  1  reset, asynchronous, active-low.
- rows  input  4  matrix row readback, active-high (pulled down externally), asynchronous to clk.
- cols  output  4  one-hot active-high column strobe.
- key_code  output  4  code of last accepted key, {column[1:0], row[1:0]}.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_pressed  output  1  level, high while the accepted key is held (debounced).

Behaviour:
- Reset (res=0, asynchronous): cols=4'b0001, key_code=0, key_valid=0, key_pressed=0, state=IDLE, all counters and synchronizer flops = 0. Reset mid-press aborts with no key_valid pulse.
- rows passes through a 2-flop synchronizer before use.
- Column sequencing:
  - Dwell counter div runs 0..SCAN_DIV-1; col counter advances 0..3 and wraps to 0.
  - cols = 4'b1 << col.
  - On the cycle div==SCAN_DIV-1, the synchronized rows are sampled into frame bits [col*4 +: 4].
- Frame end: the cycle col==3 && div==SCAN_DIV-1. The frame is classified as:
  - EMPTY: 0 bits set.
  - SINGLE(k): exactly 1 bit set; k = {col, row index}.
  - MULTI: 2 or more bits set.
- FSM, updated only at frame end; cnt is the frame counter:
  - IDLE:
    - SINGLE(k) -> DEBOUNCE, cand=k, cnt=1.
    - Otherwise stay.
  - DEBOUNCE:
    - SINGLE(cand) -> cnt+1. When cnt+1==DEBOUNCE_FRAMES -> HELD, key_code<=cand, key_pressed<=1, key_valid=1 on the next cycle only.
    - EMPTY, MULTI or SINGLE(other) -> IDLE, cnt=0.
  - HELD:
    - EMPTY -> RELEASE, cnt=1.
    - SINGLE or MULTI -> stay. No new pulse; key_code unchanged.
  - RELEASE:
    - EMPTY -> cnt+1. When cnt+1==DEBOUNCE_FRAMES -> IDLE, key_pressed<=0.
    - Any non-empty frame -> HELD, cnt=0. No new pulse.
- key_valid is never high for more than one cycle and only ever fires on a DEBOUNCE->HELD transition.
- key_code holds its value after release until the next accepted key.
- Latency: press stable from frame f onward -> key_valid high in the cycle after the frame end of frame f+DEBOUNCE_FRAMES-1. Frame length = 4*SCAN_DIV cycles.
- Counters wrap without glitching; cols is always exactly one-hot.

Test Plan:
- Reset: res low mid-scan, with SCAN_DIV=4 and DEBOUNCE_FRAMES=3 -> cols=0001, key_code=0, key_valid=0, key_pressed=0 immediately and asynchronously. Release res -> cols walks 0001,0010,0100,1000 every 4 cycles, then wraps.
- Clean press: row1 asserted whenever cols==0100, held for 5 frames -> exactly one key_valid pulse after the 3rd full frame; key_code=4'h9; key_pressed=1. Remove the key -> key_pressed=0 after 3 empty frames; key_code stays 9.
- Bounce: key (col0,row0) present for 2 frames, absent 1 frame, present 3 frames -> single key_valid, code 4'h0, after the final 3rd consecutive frame; no pulse earlier.
- Multi-key: keys 4'h3 and 4'hC both pressed for 6 frames -> no key_valid, key_pressed=0. Then hold only 4'hC for 3 frames -> pulse with code 4'hC.
- Release glitch: held key 4'h5 drops out for 1 frame then returns -> key_pressed stays 1; no second key_valid.
- Reset during DEBOUNCE: 2 matching frames of 4'h7, then res pulse -> no key_valid. After reset, 3 fresh frames are required before the pulse.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Key matrix / key event interface for keypad_scanner.
// master: the scanner (drives column strobes and key events, reads rows).
// slave:  the matrix plus its consumer (drives rows, reads everything else).
interface keypad_scanner_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pressed;

  modport master (
    input  rows,
    output cols,
    output key_code,
    output key_valid,
    output key_pressed
  );

  modport slave (
    output rows,
    input  cols,
    input  key_code,
    input  key_valid,
    input  key_pressed
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: walks a one-hot column strobe, gathers the row
// readback into a 16-bit frame, debounces whole frames and reports a single
// accepted key as a code, a one-cycle valid pulse and a held level.
module keypad_scanner #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic              clk,
  input  logic              res,
  keypad_scanner_if.master  kp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  logic [3:0]       rows_s1_q, rows_s2_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [15:0]      frame_q, frame_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_pressed_q, key_pressed_d;
  logic             sample, frame_end;
  logic [4:0]       bit_count;
  logic [3:0]       bit_index;

  // Two-flop synchronizer for the asynchronous row readback.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of the others; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rows_s1_q <= '0;
      rows_s2_q <= '0;
    end else begin
      rows_s1_q <= kp.rows;
      rows_s2_q <= rows_s1_q;
    end
  end

  // Dwell/column counters and frame assembly; the last dwell cycle of a
  // column latches its rows, which are two cycles old but from the same column.
  // NOTE: every always_comb output is defaulted first so no path infers a latch.
  always_comb begin
    sample    = (div_q == DIV_LAST);
    frame_end = sample && (col_q == 2'd3);
    div_d     = sample ? '0 : div_q + DIV_W'(1);
    col_d     = sample ? col_q + 2'd1 : col_q;
    frame_d   = frame_q;
    if (sample) frame_d[{col_q, 2'b00} +: 4] = rows_s2_q;
  end

  // Classify the frame as seen at frame end (includes the column just sampled).
  always_comb begin
    bit_count = '0;
    bit_index = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame_d[i]) begin
        bit_count = bit_count + 5'd1;
        bit_index = 4'(i);
      end
    end
  end

  // Debounce FSM next-state and outputs; evaluated only at frame end.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cnt_inc       = cnt_q + CNT_W'(1);
    cand_d        = cand_q;
    key_code_d    = key_code_q;
    key_pressed_d = key_pressed_q;
    key_valid_d   = 1'b0;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (bit_count == 5'd1) begin
            state_d = DEBOUNCE;
            cand_d  = bit_index;
            cnt_d   = CNT_W'(1);
          end
        end
        DEBOUNCE: begin
          if (bit_count == 5'd1 && bit_index == cand_q) begin
            if (cnt_inc == CNT_DONE) begin
              state_d       = HELD;
              cnt_d         = '0;
              key_code_d    = cand_q;
              key_pressed_d = 1'b1;
              key_valid_d   = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          if (bit_count == 5'd0) begin
            state_d = RELEASE;
            cnt_d   = CNT_W'(1);
          end
        end
        RELEASE: begin
          if (bit_count == 5'd0) begin
            if (cnt_inc == CNT_DONE) begin
              state_d       = IDLE;
              cnt_d         = '0;
              key_pressed_d = 1'b0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = HELD;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Scan counters and frame register.
  // NOTE: the frame register is reset even though each bit is rewritten before
  // it is classified, so nothing unknown can ever reach the classifier.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      div_q   <= '0;
      col_q   <= '0;
      frame_q <= '0;
    end else begin
      div_q   <= div_d;
      col_q   <= col_d;
      frame_q <= frame_d;
    end
  end

  // FSM state and key outputs.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cand_q        <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cand_q        <= cand_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_pressed_q <= key_pressed_d;
    end
  end

  assign kp.cols        = 4'b0001 << col_q;
  assign kp.key_code    = key_code_q;
  assign kp.key_valid   = key_valid_q;
  assign kp.key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a 4x4 matrix model, directed frame
// tables for the listed scenarios, a mid-scan reset and random frames checked
// against a frame-level reference model.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DF       = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  typedef struct packed {
    logic [15:0] pat;
    logic        ev;
    logic        ep;
    logic [3:0]  ec;
  } vec_t;

  logic        clk = 1'b0;
  logic        res;
  logic [15:0] keys;
  logic [3:0]  rows_m;
  logic [15:0] rnd_pat;

  int n_cmp = 0;
  int n_bad = 0;

  // Frame-level reference model state.
  bit       m_pressed;
  bit       m_valid;
  logic [3:0] m_code;
  int       m_run, m_gap, m_key;

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  keypad_scanner_if kif();

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DF)) dut (
    .clk (clk),
    .res (res),
    .kp  (kif)
  );

  always #5 clk = ~clk;

  // Key matrix: a pressed key connects its column strobe to its row line.
  always_comb begin
    rows_m = '0;
    for (int c = 0; c < 4; c++)
      if (kif.cols[c]) rows_m = rows_m | keys[c*4 +: 4];
  end
  assign kif.rows = rows_m;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pressed = 0; m_valid = 0; m_code = '0; m_run = 0; m_gap = 0; m_key = 0;
  endtask

  // One whole frame of the matrix, judged by the debounce rules.
  task automatic model_frame(input logic [15:0] pat);
    int n, k;
    n = $countones(pat);
    k = 0;
    for (int i = 0; i < 16; i++) if (pat[i]) k = i;
    m_valid = 0;
    if (!m_pressed) begin
      if (n == 1) begin
        if (m_run == 0) begin m_run = 1; m_key = k; end
        else if (k == m_key) m_run++;
        else m_run = 0;
      end else begin
        m_run = 0;
      end
      if (m_run == DF) begin
        m_valid = 1; m_pressed = 1; m_code = 4'(m_key); m_run = 0; m_gap = 0;
      end
    end else begin
      if (n == 0) begin
        m_gap++;
        if (m_gap == DF) begin m_pressed = 0; m_gap = 0; end
      end else begin
        m_gap = 0;
      end
    end
  endtask

  // Checks made in cycle 0 of a frame (the cycle after the previous frame end).
  task automatic check_start();
    check("cols_c0",     16'(kif.cols),        16'h0001);
    check("key_valid",   16'(kif.key_valid),   16'(m_valid));
    check("key_pressed", 16'(kif.key_pressed), 16'(m_pressed));
    check("key_code",    16'(kif.key_code),    16'(m_code));
  endtask

  // Entered at the negedge of cycle 0 of a frame; leaves at cycle 0 of the next.
  task automatic run_frame(input logic [15:0] pat);
    check_start();
    keys = pat;
    for (int c = 1; c < FRAME; c++) begin
      @(posedge clk); @(negedge clk);
      check("cols_walk",       16'(kif.cols),      16'(1) << (c / SCAN_DIV));
      check("key_valid_quiet", 16'(kif.key_valid), 16'h0000);
    end
    model_frame(pat);
    @(posedge clk); @(negedge clk);
  endtask

  task automatic apply_vec(input vec_t v);
    run_frame(v.pat);
    check("tbl_key_valid",   16'(kif.key_valid),   16'(v.ev));
    check("tbl_key_pressed", 16'(kif.key_pressed), 16'(v.ep));
    check("tbl_key_code",    16'(kif.key_code),    16'(v.ec));
  endtask

  initial begin
    // Clean press of 4'h9, then release.
    repeat (2) tbl_a.push_back('{16'h0200, 1'b0, 1'b0, 4'h0});
    tbl_a.push_back('{16'h0200, 1'b1, 1'b1, 4'h9});
    repeat (2) tbl_a.push_back('{16'h0200, 1'b0, 1'b1, 4'h9});
    repeat (2) tbl_a.push_back('{16'h0000, 1'b0, 1'b1, 4'h9});
    tbl_a.push_back('{16'h0000, 1'b0, 1'b0, 4'h9});
    // Bouncy press of 4'h0: 2 present, 1 absent, 3 present.
    repeat (2) tbl_a.push_back('{16'h0001, 1'b0, 1'b0, 4'h9});
    tbl_a.push_back('{16'h0000, 1'b0, 1'b0, 4'h9});
    repeat (2) tbl_a.push_back('{16'h0001, 1'b0, 1'b0, 4'h9});
    tbl_a.push_back('{16'h0001, 1'b1, 1'b1, 4'h0});
    repeat (2) tbl_a.push_back('{16'h0000, 1'b0, 1'b1, 4'h0});
    tbl_a.push_back('{16'h0000, 1'b0, 1'b0, 4'h0});
    // Multi-key 4'h3 + 4'hC, then 4'hC alone.
    repeat (6) tbl_a.push_back('{16'h1008, 1'b0, 1'b0, 4'h0});
    repeat (2) tbl_a.push_back('{16'h1000, 1'b0, 1'b0, 4'h0});
    tbl_a.push_back('{16'h1000, 1'b1, 1'b1, 4'hC});
    repeat (2) tbl_a.push_back('{16'h0000, 1'b0, 1'b1, 4'hC});
    tbl_a.push_back('{16'h0000, 1'b0, 1'b0, 4'hC});
    // Release glitch on held 4'h5.
    repeat (2) tbl_a.push_back('{16'h0020, 1'b0, 1'b0, 4'hC});
    tbl_a.push_back('{16'h0020, 1'b1, 1'b1, 4'h5});
    tbl_a.push_back('{16'h0000, 1'b0, 1'b1, 4'h5});
    repeat (2) tbl_a.push_back('{16'h0020, 1'b0, 1'b1, 4'h5});
    repeat (2) tbl_a.push_back('{16'h0000, 1'b0, 1'b1, 4'h5});
    tbl_a.push_back('{16'h0000, 1'b0, 1'b0, 4'h5});
    // Two matching frames of 4'h7 before a reset.
    repeat (2) tbl_a.push_back('{16'h0080, 1'b0, 1'b0, 4'h5});
    // After the reset, three fresh frames are needed.
    repeat (2) tbl_b.push_back('{16'h0080, 1'b0, 1'b0, 4'h0});
    tbl_b.push_back('{16'h0080, 1'b1, 1'b1, 4'h7});

    keys = '0;
    res  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_cols",        16'(kif.cols),        16'h0001);
    check("rst_key_code",    16'(kif.key_code),    16'h0000);
    check("rst_key_valid",   16'(kif.key_valid),   16'h0000);
    check("rst_key_pressed", 16'(kif.key_pressed), 16'h0000);
    res = 1'b1;

    foreach (tbl_a[i]) apply_vec(tbl_a[i]);

    // Asynchronous reset mid-scan, part way into the second column.
    keys = 16'h0080;
    repeat (5) @(posedge clk);
    #3 res = 1'b0;
    #1;
    check("async_rst_cols",        16'(kif.cols),        16'h0001);
    check("async_rst_key_code",    16'(kif.key_code),    16'h0000);
    check("async_rst_key_valid",   16'(kif.key_valid),   16'h0000);
    check("async_rst_key_pressed", 16'(kif.key_pressed), 16'h0000);
    @(negedge clk);
    res = 1'b1;
    model_reset();

    foreach (tbl_b[i]) apply_vec(tbl_b[i]);

    // Random frames: patterns tend to persist so presses get through debounce.
    rnd_pat = '0;
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 9) >= 6) begin
        case ($urandom_range(0, 9))
          0, 1, 2:       rnd_pat = '0;
          3, 4, 5, 6, 7: rnd_pat = 16'h0001 << $urandom_range(0, 15);
          default:       rnd_pat = (16'h0001 << $urandom_range(0, 15)) |
                                   (16'h0001 << $urandom_range(0, 15));
        endcase
      end
      run_frame(rnd_pat);
    end
    check_start();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
